// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, decoder BS/MD codes and
// the instruction width.
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W = 17;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback
  } seq_state_e;

  localparam logic [1:0] BS_NEXT = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JREG = 2'b10;
  localparam logic [1:0] BS_JUMP = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IN  = 2'b10;

  // A data-memory cycle is needed for stores and for loads through the MEM mux leg.
  function automatic logic is_mem_op(input logic mw, input logic [1:0] md);
    logic md_mem;
    case (md)
      MD_MEM:        md_mem = 1'b1;
      MD_ALU, MD_IN: md_mem = 1'b0;
      default:       md_mem = 1'b0;
    endcase
    return mw | md_mem;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with branch resolution: resolve latches taken/target in EXECUTE,
// load commits pc <= taken ? target : pc + 1 in WRITEBACK.
module pc_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      OFF_W    = 9,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resolve,
  input  logic              load,
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              zero_flag,
  input  logic [PC_W-1:0]   jreg_target,
  input  logic [OFF_W-1:0]  offset,
  output logic [PC_W-1:0]   pc
);

  localparam int unsigned SUM_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  logic [PC_W-1:0]  pc_q;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic [SUM_W-1:0] rel_sum;

  // Sign-extend the offset; the sum wraps modulo 2^PC_W by truncation.
  assign rel_sum = SUM_W'(pc_q) + SUM_W'($signed(offset));

  always_comb begin
    taken_d  = 1'b0;
    target_d = rel_sum[PC_W-1:0];
    case (bs)
      BS_NEXT: taken_d = 1'b0;
      BS_COND: taken_d = zero_flag != ps;
      BS_JREG: begin
        taken_d  = 1'b1;
        target_d = jreg_target;
      end
      BS_JUMP: taken_d = !ps || !zero_flag;
      default: taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      if (resolve) begin
        taken_q  <= taken_d;
        target_q <= target_d;
      end
      if (load) begin
        pc_q <= taken_q ? target_q : pc_q + PC_W'(1);
      end
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback controller gating decoder strobes.
// Define SEQ_TIMEOUT_EN to add the ack-wait timeout and the sticky seq_err output.
module instruction_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OFF_W       = 9,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               dec_rw,
  input  logic               dec_mw,
  input  logic               dec_out_we,
  input  logic [1:0]         dec_md,
  input  logic [1:0]         dec_bs,
  input  logic               dec_ps,
  input  logic               zero_flag,
  input  logic [DATA_W-1:0]  bus_a,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic               out_we,
  output logic [PC_W-1:0]    pc,
  output logic               busy
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic               seq_err
`endif
);

  seq_state_e         state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_load, resolve, pc_load, tmo_hit;
  logic               unused_bus_a_hi;

  assign unused_bus_a_hi = ^bus_a[DATA_W-1:PC_W];

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;
  logic       seq_err_q, waiting;

  assign waiting = (state_q == StFetch && !imem_ack) || (state_q == StMem && !dmem_ack);
  assign tmo_hit = waiting && (wait_q == 4'(TIMEOUT_CYC - 1));
  assign wait_d  = waiting ? wait_q + 4'd1 : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= 4'd0;
      seq_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      seq_err_q <= seq_err_q | tmo_hit;
    end
  end

  assign seq_err = seq_err_q;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    resolve = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      StIdle: if (run) state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        resolve = 1'b1;
        state_d = is_mem_op(dec_mw, dec_md) ? StMem : StWriteback;
      end
      StMem: begin
        if (dmem_ack) state_d = StWriteback;
        else if (tmo_hit) state_d = StIdle;
      end
      StWriteback: begin
        pc_load = 1'b1;
        state_d = run ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= imem_rdata;
    end
  end

  pc_unit #(
    .PC_W     (PC_W),
    .OFF_W    (OFF_W),
    .RESET_PC (PC_W'(RESET_PC))
  ) u_pc_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .resolve     (resolve),
    .load        (pc_load),
    .bs          (dec_bs),
    .ps          (dec_ps),
    .zero_flag   (zero_flag),
    .jreg_target (bus_a[PC_W-1:0]),
    .offset      (ir_q[OFF_W-1:0]),
    .pc          (pc)
  );

  assign ir        = ir_q;
  assign imem_req  = state_q == StFetch;
  assign imem_addr = pc;
  assign dmem_req  = state_q == StMem;
  assign dmem_we   = dmem_req & dec_mw;
  assign out_we    = dmem_req & dmem_ack & dec_out_we;
  assign rf_we     = (state_q == StWriteback) & dec_rw;
  assign busy      = state_q != StIdle;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: the driver plays memories/decoder and queues expected per-instruction
// observations from a reference model; a monitor rebuilds what the DUT did and compares.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [7:0]  imem_addr, pc;
  logic [16:0] imem_rdata = '0, ir;
  logic        dec_rw = 0, dec_mw = 0, dec_out_we = 0, dec_ps = 0, zero_flag = 0;
  logic [1:0]  dec_md = '0, dec_bs = '0;
  logic [15:0] bus_a = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, out_we, busy;
`ifdef SEQ_TIMEOUT_EN
  logic        seq_err;
`endif

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .dec_rw     (dec_rw),
    .dec_mw     (dec_mw),
    .dec_out_we (dec_out_we),
    .dec_md     (dec_md),
    .dec_bs     (dec_bs),
    .dec_ps     (dec_ps),
    .zero_flag  (zero_flag),
    .bus_a      (bus_a),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .out_we     (out_we),
    .pc         (pc),
    .busy       (busy)
`ifdef SEQ_TIMEOUT_EN
    ,
    .seq_err    (seq_err)
`endif
  );

  typedef struct {
    int addr;
    int ir_first;
    int ir_last;
    int dcyc;
    int dwe;
    int out_cnt;
    int out_off;
    int rf_cnt;
    int rf_off;
    int end_off;
  } rec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   model_pc = 0;
  rec_t exp_q[$];
  bit   mon_en = 0;
  bit   flush = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Architectural next-PC straight from the branch table.
  function automatic int ref_next_pc(input int cur, input logic [16:0] rd, input logic [1:0] bs,
                                     input logic ps, input logic zf, input logic [15:0] ba);
    int off;
    int seq;
    int rel;
    off = int'(rd[8:0]);
    if (off >= 256) off -= 512;
    seq = (cur + 1) & 255;
    rel = (cur + off) & 255;
    case (bs)
      2'd0:    return seq;
      2'd1:    return (zf != ps) ? rel : seq;
      2'd2:    return int'(ba) & 255;
      default: return (ps && zf) ? seq : rel;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic abort(input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: handshake never arrived, got timeout, expected response", what);
    finish_run();
  endtask

  task automatic issue(input logic [16:0] rd, input logic rw, input logic mw, input logic ow,
                       input logic [1:0] md, input logic [1:0] bs, input logic ps,
                       input logic zf, input logic [15:0] ba, input int iw, input int dw,
                       input bit drop_dec, input bit drop_mem);
    rec_t e;
    int   n;
    bit   mem;
    int   mc;
    mem = mw || (md == 2'b01);
    mc  = mem ? dw + 1 : 0;
    e.addr     = model_pc;
    e.ir_first = int'(rd);
    e.ir_last  = int'(rd);
    e.dcyc     = mc;
    e.dwe      = mem ? int'(mw) : 0;
    e.out_cnt  = (mem && ow) ? 1 : 0;
    e.out_off  = (mem && ow) ? 2 + mc : -1;
    e.rf_cnt   = int'(rw);
    e.rf_off   = rw ? 3 + mc : -1;
    e.end_off  = 4 + mc;
    exp_q.push_back(e);
    model_pc = ref_next_pc(model_pc, rd, bs, ps, zf, ba);

    if (!run) begin
      step();
      run = 1'b1;
    end
    n = 0;
    while (!imem_req) begin
      if (n++ > 40) abort("fetch_wait");
      step();
    end
    dec_rw = rw; dec_mw = mw; dec_out_we = ow; dec_md = md; dec_bs = bs; dec_ps = ps;
    zero_flag = zf; bus_a = ba;
    repeat (iw) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      imem_rdata = 17'($urandom);
      step();
    end
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    imem_rdata = rd;
    step();
    imem_ack = 1'b0;
    imem_rdata = 17'($urandom);
    if (drop_dec) run = 1'b0;
    if (mem) begin
      n = 0;
      while (!dmem_req) begin
        if (n++ > 10) abort("dmem_req_wait");
        imem_ack = 1'($urandom_range(0, 1));
        step();
      end
      if (drop_mem) run = 1'b0;
      repeat (dw) begin
        dmem_ack = 1'b0;
        imem_ack = 1'($urandom_range(0, 1));
        step();
      end
      dmem_ack = 1'b1;
      imem_ack = 1'b0;
      step();
      dmem_ack = 1'b0;
    end
    if (drop_dec || drop_mem) begin
      n = 0;
      while (busy) begin
        if (n++ > 20) abort("busy_fall");
        step();
      end
      step();
    end
  endtask

  // Monitor: one observed record per fetch handshake, closed at the next fetch or on flush.
  rec_t mon_rec;
  bit   mon_open = 0;
  int   mon_cyc = 0;
  int   mon_ack = 0;

  task automatic close_rec();
    rec_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_instr: got fetch at 0x%0h, expected none", mon_rec.addr);
    end else begin
      e = exp_q.pop_front();
      check("fetch_addr", mon_rec.addr, e.addr);
      check("ir_loaded", mon_rec.ir_first, e.ir_first);
      check("ir_held", mon_rec.ir_last, e.ir_last);
      check("dmem_req_cycles", mon_rec.dcyc, e.dcyc);
      check("dmem_we", mon_rec.dwe, e.dwe);
      check("out_we_pulses", mon_rec.out_cnt, e.out_cnt);
      check("out_we_cycle", mon_rec.out_off, e.out_off);
      check("rf_we_pulses", mon_rec.rf_cnt, e.rf_cnt);
      check("rf_we_cycle", mon_rec.rf_off, e.rf_off);
      check("instr_end_cycle", mon_rec.end_off, e.end_off);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!mon_en) begin
        mon_open = 0;
      end else begin
        if (mon_open && mon_cyc > mon_ack) begin
          mon_rec.ir_last = int'(ir);
          if (mon_cyc == mon_ack + 1) mon_rec.ir_first = int'(ir);
          if (dmem_req) begin
            mon_rec.dcyc++;
            if (dmem_we) mon_rec.dwe = 1;
          end
          if (out_we) begin
            mon_rec.out_cnt++;
            mon_rec.out_off = mon_cyc - mon_ack;
          end
          if (rf_we) begin
            mon_rec.rf_cnt++;
            mon_rec.rf_off = mon_cyc - mon_ack;
          end
          if (mon_rec.end_off < 0 && (imem_req || !busy)) mon_rec.end_off = mon_cyc - mon_ack;
        end
        if (mon_open && (flush || (imem_req && imem_ack))) begin
          close_rec();
          mon_open = 0;
        end
        if (imem_req && imem_ack && !flush) begin
          mon_open = 1;
          mon_ack  = mon_cyc;
          mon_rec  = '{addr: int'(imem_addr), ir_first: -1, ir_last: -1, dcyc: 0, dwe: 0,
                       out_cnt: 0, out_off: -1, rf_cnt: 0, rf_off: -1, end_off: -1};
        end
      end
    end
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_out_we", out_we, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_without_run", imem_req, 0);
    model_pc = 0;
    mon_en = 1;

    // ADD, JMR to 0x10, BZ back to 0x00, JMR 0x10, BZ not taken, JMR 0x1234, ST, OUT,
    // LD with run dropped in MEM, JMR 0xFF, NOP wrapping to 0x00.
    issue(17'h00000, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 0, 0);
    issue(17'h00000, 0, 0, 0, 2'b00, 2'b10, 0, 0, 16'h0010, 0, 0, 0, 0);
    issue(17'h001F0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 16'h0000, 0, 0, 0, 0);
    issue(17'h00000, 0, 0, 0, 2'b00, 2'b10, 0, 0, 16'h0010, 1, 0, 0, 0);
    issue(17'h001F0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 16'h0000, 0, 0, 0, 0);
    issue(17'h00003, 0, 0, 0, 2'b00, 2'b10, 0, 0, 16'h1234, 0, 0, 0, 0);
    issue(17'h0A5A5, 0, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 3, 0, 0);
    issue(17'h12345, 0, 0, 1, 2'b01, 2'b00, 0, 0, 16'h0000, 2, 2, 0, 0);
    issue(17'h00777, 1, 0, 0, 2'b01, 2'b00, 0, 0, 16'h0000, 0, 1, 0, 1);
    issue(17'h00000, 0, 0, 0, 2'b00, 2'b10, 0, 0, 16'hABFF, 0, 0, 0, 0);
    issue(17'h1ABCD, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      issue(17'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
            2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0);
    end
    issue(17'h1C3C3, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 1, 0);

    repeat (3) step();
    flush = 1;
    step();
    step();
    flush = 0;
    mon_en = 0;
    check("queue_drained", exp_q.size(), 0);
    check("final_pc", pc, model_pc);
    check("final_idle", busy, 0);

    // Reset landing in the middle of a FETCH wait.
    run = 1'b1;
    n = 0;
    while (!imem_req) begin
      if (n++ > 10) abort("refetch_wait");
      step();
    end
    check("prerst_fetch_addr", imem_addr, model_pc);
    rst_n = 1'b0;
    #1;
    check("midfetch_rst_imem_req", imem_req, 0);
    check("midfetch_rst_busy", busy, 0);
    check("midfetch_rst_pc", pc, 0);
    check("midfetch_rst_ir", ir, 0);
    step();
    rst_n = 1'b1;
    n = 0;
    while (!imem_req) begin
      if (n++ > 10) abort("postrst_fetch_wait");
      step();
    end
    check("postrst_fetch_addr", imem_addr, 0);
    run = 1'b0;
    step();
    finish_run();
  end

endmodule
